gfp_mul_red_pipe: RTL and testbench

//   Pipelined multi-lane GF(P) multiplier with Barrett reduction and optional
//   per-lane modular multiply-accumulate. Accepts one operand vector per cycle
//   and returns (a*b) mod P, or (acc + a*b) mod P, after a fixed 3-cycle latency.

---
 rtl/gfp_mul_red_pipe.sv | 108 ++++++++++
 tb/tb_gfp_mul_red_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gfp_mul_red_pipe.sv
// Three-stage multi-lane GF(P) multiplier with Barrett reduction and per-lane
// modular multiply-accumulate; one operand vector per cycle, no stalls.
module gfp_mul_red_pipe #(
  parameter int unsigned P     = 251,
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic               i_acc_clr,
  input  logic [LANES*W-1:0] i_a,
  input  logic [LANES*W-1:0] i_b,
  output logic [LANES*W-1:0] o_c,
  output logic               o_done
);

  localparam int unsigned XW = 2 * W;  // unreduced product width
  localparam int unsigned RW = W + 2;  // Barrett remainder width, holds r < 3P
  localparam int unsigned SW = W + 1;  // accumulate sum width, holds s < 2P

  localparam longint unsigned MuFull = (64'd1 << XW) / P;
  localparam logic [XW-1:0]   Mu     = XW'(MuFull);
  localparam logic [XW-1:0]   PX     = XW'(P);
  localparam logic [RW-1:0]   PR     = RW'(P);
  localparam logic [SW-1:0]   PS     = SW'(P);

  if (P < 2 || longint'(P) >= (64'd1 << W)) begin : g_bad_p
    $error("gfp_mul_red_pipe: P must satisfy 2 <= P < 2^W");
  end

  logic               s1_valid_q, s1_mode_q, s1_clr_q;
  logic               s2_valid_q, s2_mode_q, s2_clr_q;
  logic               done_q;
  logic [LANES*W-1:0] c_q, c_d;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [XW-1:0]   x_d, x_q;
    logic [2*XW-1:0] xmu;
    logic [XW-1:0]   q, qp, diff;
    logic [RW-1:0]   r_q, m1, m;
    logic [SW-1:0]   base, sum, s;
    logic [W-1:0]    acc_q;
    logic            unused_bits;

    assign x_d  = {{W{1'b0}}, i_a[k*W +: W]} * {{W{1'b0}}, i_b[k*W +: W]};

    // q never exceeds floor(x/P), so x - q*P fits in 2W bits and is below 3P.
    assign xmu  = {{XW{1'b0}}, x_q} * {{XW{1'b0}}, Mu};
    assign q    = xmu[2*XW-1:XW];
    assign qp   = q * PX;
    assign diff = x_q - qp;

    assign m1   = (r_q >= PR) ? r_q - PR : r_q;
    assign m    = (m1 >= PR) ? m1 - PR : m1;

    assign base = s2_clr_q ? '0 : {1'b0, acc_q};
    assign sum  = base + {1'b0, m[W-1:0]};
    assign s    = (sum >= PS) ? sum - PS : sum;

    assign c_d[k*W +: W] = s2_mode_q ? s[W-1:0] : m[W-1:0];

    assign unused_bits = ^{xmu, diff, m, s};

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        x_q   <= '0;
        r_q   <= '0;
        acc_q <= '0;
      end else begin
        x_q <= x_d;
        r_q <= diff[RW-1:0];
        if (s2_valid_q && s2_mode_q) begin
          acc_q <= s[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_clr_q   <= 1'b0;
      done_q     <= 1'b0;
      c_q        <= '0;
    end else begin
      s1_valid_q <= i_start;
      s1_mode_q  <= i_mode;
      s1_clr_q   <= i_acc_clr;
      s2_valid_q <= s1_valid_q;
      s2_mode_q  <= s1_mode_q;
      s2_clr_q   <= s1_clr_q;
      done_q     <= s2_valid_q;
      if (s2_valid_q) begin
        c_q <= c_d;
      end
    end
  end

  assign o_c    = c_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_gfp_mul_red_pipe.sv
// Scoreboard bench for gfp_mul_red_pipe: default instance (P=251, W=8, 4 lanes)
// and a wide instance (P=3329, W=12, 2 lanes), checked against a modular model.
module tb_gfp_mul_red_pipe;
  localparam int unsigned P0 = 251;
  localparam int unsigned W0 = 8;
  localparam int unsigned L0 = 4;
  localparam int unsigned P1 = 3329;
  localparam int unsigned W1 = 12;
  localparam int unsigned L1 = 2;

  typedef struct {
    logic [31:0] c;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st0, md0, clr0, done0;
  logic [31:0] a0, b0, c0;
  logic        st1, md1, clr1, done1;
  logic [23:0] a1, b1, c1;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned acc0[L0];
  int unsigned acc1[L1];
  logic [31:0] last0, last1;
  logic        rst_seen;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  gfp_mul_red_pipe #(.P(P0), .W(W0), .LANES(L0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(st0), .i_mode(md0), .i_acc_clr(clr0),
    .i_a(a0), .i_b(b0), .o_c(c0), .o_done(done0)
  );

  gfp_mul_red_pipe #(.P(P1), .W(W1), .LANES(L1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(st1), .i_mode(md1), .i_acc_clr(clr1),
    .i_a(a1), .i_b(b1), .o_c(c1), .o_done(done1)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_seen <= rst;
  end

  function automatic int unsigned mulmod(input int unsigned a, input int unsigned b,
                                         input int unsigned p);
    longint unsigned prod;
    prod = longint'(a) * longint'(b);
    return int'(prod % longint'(p));
  endfunction

  function automatic logic [31:0] rep0(input int unsigned v);
    logic [7:0] e;
    e = v[7:0];
    return {4{e}};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send0(input logic md, input logic clr, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t        e;
    int unsigned m, s;
    st0 = 1'b1; md0 = md; clr0 = clr; a0 = a; b0 = b;
    e.c = '0;
    e.cyc = cyc;
    for (int k = 0; k < L0; k++) begin
      m = mulmod(32'(a[k*W0 +: W0]), 32'(b[k*W0 +: W0]), P0);
      if (md) begin
        s = ((clr ? 0 : acc0[k]) + m) % P0;
        acc0[k] = s;
        e.c[k*W0 +: W0] = s[W0-1:0];
      end else begin
        e.c[k*W0 +: W0] = m[W0-1:0];
      end
    end
    q0.push_back(e);
    idle(1);
    st0 = 1'b0;
  endtask

  task automatic send1(input logic md, input logic clr, input logic [23:0] a,
                       input logic [23:0] b);
    exp_t        e;
    int unsigned m, s;
    st1 = 1'b1; md1 = md; clr1 = clr; a1 = a; b1 = b;
    e.c = '0;
    e.cyc = cyc;
    for (int k = 0; k < L1; k++) begin
      m = mulmod(32'(a[k*W1 +: W1]), 32'(b[k*W1 +: W1]), P1);
      if (md) begin
        s = ((clr ? 0 : acc1[k]) + m) % P1;
        acc1[k] = s;
        e.c[k*W1 +: W1] = s[W1-1:0];
      end else begin
        e.c[k*W1 +: W1] = m[W1-1:0];
      end
    end
    q1.push_back(e);
    idle(1);
    st1 = 1'b0;
  endtask

  // Monitor: every done pops one expectation; otherwise o_c must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      last0 = '0;
      last1 = '0;
    end
    checks++;
    if (done0) begin
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_done got c=%h expected no output", c0);
        last0 = c0;
      end else begin
        e = q0.pop_front();
        if (c0 !== e.c || cyc != e.cyc + 3) begin
          errors++;
          $display("FAIL dut0_result got c=%h at cycle %0d expected c=%h at cycle %0d",
                   c0, cyc, e.c, e.cyc + 3);
        end
        last0 = e.c;
      end
    end else if (c0 !== last0) begin
      errors++;
      $display("FAIL dut0_hold got c=%h expected %h", c0, last0);
    end
    checks++;
    if (done1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_done got c=%h expected no output", c1);
        last1 = {8'd0, c1};
      end else begin
        e = q1.pop_front();
        if ({8'd0, c1} !== e.c || cyc != e.cyc + 3) begin
          errors++;
          $display("FAIL dut1_result got c=%h at cycle %0d expected c=%h at cycle %0d",
                   c1, cyc, e.c, e.cyc + 3);
        end
        last1 = e.c;
      end
    end else if ({8'd0, c1} !== last1) begin
      errors++;
      $display("FAIL dut1_hold got c=%h expected %h", c1, last1);
    end
  end

  initial begin
    rst = 1'b1;
    st0 = 1'b1; md0 = 1'b0; clr0 = 1'b0; a0 = '0; b0 = '0;
    st1 = 1'b1; md1 = 1'b0; clr1 = 1'b0; a1 = '0; b1 = '0;
    last0 = '0; last1 = '0;
    for (int k = 0; k < L0; k++) acc0[k] = 0;
    for (int k = 0; k < L1; k++) acc1[k] = 0;

    // Reset held with start asserted, then three quiet cycles after release.
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 3) begin
        rst = 1'b0;
        st0 = 1'b0;
        st1 = 1'b0;
      end else begin
        a0 = $urandom; b0 = $urandom;
      end
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || c0 !== '0 || done1 !== 1'b0 || c1 !== '0) begin
        errors++;
        $display("FAIL reset_quiet got done0=%b c0=%h done1=%b c1=%h expected zeros",
                 done0, c0, done1, c1);
      end
      @(posedge clk);
    end
    #1;

    // Lane edges: 0*7, 1*1, 250*250, 255*255.
    send0(1'b0, 1'b0, {8'd255, 8'd250, 8'd1, 8'd0}, {8'd255, 8'd250, 8'd1, 8'd7});
    idle(5);

    for (int i = 0; i < 256; i++) send0(1'b0, 1'b0, $urandom, $urandom);
    idle(5);

    send0(1'b1, 1'b1, rep0(2), rep0(3));
    send0(1'b1, 1'b0, rep0(100), rep0(100));
    send0(1'b1, 1'b0, rep0(200), rep0(200));
    send0(1'b0, 1'b0, rep0(5), rep0(5));
    send0(1'b1, 1'b0, rep0(1), rep0(1));
    idle(5);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0)
        send0(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom, $urandom);
      else
        idle(1);
    end
    idle(5);

    // Reset with two MAC vectors in flight: both are dropped, accumulators cleared.
    send0(1'b1, 1'b0, rep0(9), rep0(9));
    send0(1'b1, 1'b0, rep0(3), rep0(3));
    rst = 1'b1;
    q0.delete();
    q1.delete();
    for (int k = 0; k < L0; k++) acc0[k] = 0;
    for (int k = 0; k < L1; k++) acc1[k] = 0;
    idle(2);
    rst = 1'b0;
    idle(4);
    send0(1'b1, 1'b0, rep0(4), rep0(4));
    idle(5);

    send1(1'b0, 1'b0, {12'd4095, 12'd3328}, {12'd4095, 12'd3328});
    idle(4);
    for (int i = 0; i < 60; i++) begin
      send1(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 24'($urandom),
            24'($urandom));
    end
    idle(6);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got pending0=%0d pending1=%0d expected 0 and 0",
               q0.size(), q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
